// File: rtl/aibcr3pnr_bsr_chain_ctrl_if.sv
// Host-side request/response bundle for the BSR chain sequencer.
// Master is the TAP/DFT host, slave is the sequencer.
interface aibcr3pnr_bsr_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 16
);
  logic                 req;
  logic                 abort;
  logic [CHAIN_LEN-1:0] wdata;
  logic                 cfg_mode;
  logic                 cfg_intest;
  logic                 cfg_rstb_en;
  logic                 cfg_rstb;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] rdata;

  modport master (
    output req, abort, wdata, cfg_mode, cfg_intest, cfg_rstb_en, cfg_rstb,
    input  busy, done, rdata
  );

  modport slave (
    input  req, abort, wdata, cfg_mode, cfg_intest, cfg_rstb_en, cfg_rstb,
    output busy, done, rdata
  );
endinterface

// File: rtl/aibcr3pnr_bsr_chain_ctrl.sv
// Initiator-side sequencer for the AIB JTAG boundary-scan chain: one capture
// pulse, then CHAIN_LEN shift pulses, with serial write-in and parallel read-back.
module aibcr3pnr_bsr_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                             clk,
  input  logic                             rstb,
  aibcr3pnr_bsr_chain_ctrl_if.slave        host,
  output logic                             jtag_clkdr_out,
  output logic                             jtag_tx_scanen_out,
  output logic                             jtag_tx_scan_out,
  input  logic                             jtag_rx_scan_in,
  output logic                             jtag_mode_out,
  output logic                             jtag_intest_out,
  output logic                             jtag_rstb_en_out,
  output logic                             jtag_rstb_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
  logic                 clkdr_q, clkdr_d;
  logic                 scanen_q, scanen_d;
  logic                 tx_q, tx_d;
  logic                 mode_q, mode_d;
  logic                 intest_q, intest_d;
  logic                 rstb_en_q, rstb_en_d;
  logic                 rstb_out_q, rstb_out_d;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      clkdr_q    <= 1'b0;
      scanen_q   <= 1'b0;
      tx_q       <= 1'b0;
      mode_q     <= 1'b0;
      intest_q   <= 1'b0;
      rstb_en_q  <= 1'b0;
      rstb_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      clkdr_q    <= clkdr_d;
      scanen_q   <= scanen_d;
      tx_q       <= tx_d;
      mode_q     <= mode_d;
      intest_q   <= intest_d;
      rstb_en_q  <= rstb_en_d;
      rstb_out_q <= rstb_out_d;
    end
  end

  // phase 0 = clkdr low (L), phase 1 = clkdr high (H); the shift happens as H closes
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        if (host.req) begin
          state_d = S_CAPTURE;
          phase_d = 1'b0;
          cnt_d   = '0;
          sr_d    = host.wdata;
        end
      end
      S_CAPTURE: begin
        if (host.abort) begin
          state_d = S_IDLE;
          phase_d = 1'b0;
          cnt_d   = '0;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d = S_SHIFT;
          phase_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (host.abort) begin
          state_d = S_IDLE;
          phase_d = 1'b0;
          cnt_d   = '0;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          sr_d    = {jtag_rx_scan_in, sr_q[CHAIN_LEN-1:1]};
          phase_d = 1'b0;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state; tx follows
  // sr_d[0], which only moves when a new L phase begins.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    rdata_d    = (state_d == S_DONE) ? sr_d : rdata_q;
    clkdr_d    = ((state_d == S_CAPTURE) || (state_d == S_SHIFT)) && phase_d;
    scanen_d   = (state_d == S_SHIFT);
    tx_d       = (state_d == S_SHIFT) ? sr_d[0] : 1'b0;
    mode_d     = mode_q;
    intest_d   = intest_q;
    rstb_en_d  = rstb_en_q;
    rstb_out_d = rstb_out_q;
    if ((state_q == S_IDLE) && host.req) begin
      mode_d     = host.cfg_mode;
      intest_d   = host.cfg_intest;
      rstb_en_d  = host.cfg_rstb_en;
      rstb_out_d = host.cfg_rstb;
    end
  end

  assign host.busy          = busy_q;
  assign host.done          = done_q;
  assign host.rdata         = rdata_q;
  assign jtag_clkdr_out     = clkdr_q;
  assign jtag_tx_scanen_out = scanen_q;
  assign jtag_tx_scan_out   = tx_q;
  assign jtag_mode_out      = mode_q;
  assign jtag_intest_out    = intest_q;
  assign jtag_rstb_en_out   = rstb_en_q;
  assign jtag_rstb_out      = rstb_out_q;

endmodule

// File: tb/tb_aibcr3pnr_bsr_chain_ctrl.sv
// Directed bench for the BSR chain sequencer with a 4-bit chain: loopback,
// chain model, abort, config latch, busy-req rejection, back-to-back and reset.
module tb_aibcr3pnr_bsr_chain_ctrl;

  localparam int unsigned N = 4;

  logic clk;
  logic rstb;
  logic clkdr, scanen, tx, rx;
  logic mode, intest, rstb_en, rstb_out;
  logic loop_sel;

  // Chain model: capture loads 4'h5, shifts on clkdr rise, serial output
  // is retimed on the clkdr fall as a real scan cell presents it.
  logic [3:0] chain;
  logic       chain_rx;
  logic [7:0] tx_log;
  int         rise_cnt;

  int n_cmp;
  int n_err;

  aibcr3pnr_bsr_chain_ctrl_if #(.CHAIN_LEN(N)) hif ();

  aibcr3pnr_bsr_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(3)) dut (
    .clk                (clk),
    .rstb               (rstb),
    .host               (hif),
    .jtag_clkdr_out     (clkdr),
    .jtag_tx_scanen_out (scanen),
    .jtag_tx_scan_out   (tx),
    .jtag_rx_scan_in    (rx),
    .jtag_mode_out      (mode),
    .jtag_intest_out    (intest),
    .jtag_rstb_en_out   (rstb_en),
    .jtag_rstb_out      (rstb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rx = loop_sel ? tx : chain_rx;

  always @(posedge clkdr) begin
    rise_cnt <= rise_cnt + 1;
    if (scanen) begin
      chain  <= {tx, chain[3:1]};
      tx_log <= {tx_log[6:0], tx};
    end else begin
      chain <= 4'h5;
    end
  end

  always @(negedge clkdr) chain_rx <= chain[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, mode, intest, rstb_en, rstb_out}, {28'd0, exp});
  endtask

  // Issues one request and checks the full 2N+3 cycle sequence; ends in cycle 13.
  task automatic run_full(input string tag, input logic [3:0] wd, input logic [3:0] exp_rd);
    int base;
    base      = rise_cnt;
    hif.wdata = wd;
    hif.req   = 1'b1;
    tick();
    hif.req   = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("%s busy c%0d", tag, k),   {31'd0, hif.busy}, {31'd0, (k <= 11)});
      chk($sformatf("%s done c%0d", tag, k),   {31'd0, hif.done}, {31'd0, (k == 11)});
      chk($sformatf("%s clkdr c%0d", tag, k),  {31'd0, clkdr},    {31'd0, (k <= 10) && (k % 2 == 0)});
      chk($sformatf("%s scanen c%0d", tag, k), {31'd0, scanen},   {31'd0, (k >= 3) && (k <= 10)});
      if (k == 11) chk($sformatf("%s rdata", tag), {28'd0, hif.rdata}, {28'd0, exp_rd});
      tick();
    end
    chk($sformatf("%s clkdr rises", tag), rise_cnt - base, 32'd5);
  endtask

  initial begin
    int ndone, d1, d2, cyc;
    n_cmp          = 0;
    n_err          = 0;
    rise_cnt       = 0;
    tx_log         = '0;
    chain          = '0;
    chain_rx       = 1'b0;
    loop_sel       = 1'b1;
    rstb           = 1'b0;
    hif.req        = 1'b0;
    hif.abort      = 1'b0;
    hif.wdata      = '0;
    hif.cfg_mode   = 1'b0;
    hif.cfg_intest = 1'b0;
    hif.cfg_rstb_en = 1'b0;
    hif.cfg_rstb   = 1'b0;
    repeat (3) tick();

    chk("rst busy",   {31'd0, hif.busy}, 32'd0);
    chk("rst done",   {31'd0, hif.done}, 32'd0);
    chk("rst rdata",  {28'd0, hif.rdata}, 32'd0);
    chk("rst clkdr",  {31'd0, clkdr}, 32'd0);
    chk("rst scanen", {31'd0, scanen}, 32'd0);
    chk("rst tx",     {31'd0, tx}, 32'd0);
    chk_cfg("rst cfg", 4'b0001);
    rstb = 1'b1;
    tick();

    // Loopback, wdata=A, config 1/1/1/0
    hif.cfg_mode = 1'b1; hif.cfg_intest = 1'b1; hif.cfg_rstb_en = 1'b1; hif.cfg_rstb = 1'b0;
    run_full("loop", 4'hA, 4'hA);
    chk_cfg("cfg held after done", 4'b1110);

    // Chain model: capture 5, write 3
    loop_sel = 1'b0;
    hif.cfg_mode = 1'b0; hif.cfg_intest = 1'b0; hif.cfg_rstb_en = 1'b0; hif.cfg_rstb = 1'b0;
    run_full("chain", 4'h3, 4'h5);
    chk("chain contents", {28'd0, chain}, 32'h3);
    chk("chain tx order", {28'd0, tx_log[3:0]}, 32'hC);
    chk_cfg("cfg zeros", 4'b0000);

    // Abort at cycle 6
    loop_sel = 1'b1;
    hif.cfg_mode = 1'b1; hif.cfg_intest = 1'b0; hif.cfg_rstb_en = 1'b1; hif.cfg_rstb = 1'b1;
    hif.wdata = 4'h6;
    hif.req   = 1'b1;
    tick();
    hif.req   = 1'b0;
    chk_cfg("abort cfg c1", 4'b1011);
    ndone = 0;
    for (int k = 1; k < 6; k++) begin
      tick();
      if (hif.done) ndone++;
    end
    hif.abort = 1'b1;
    tick();
    hif.abort = 1'b0;
    chk("abort clkdr",  {31'd0, clkdr}, 32'd0);
    chk("abort scanen", {31'd0, scanen}, 32'd0);
    chk("abort tx",     {31'd0, tx}, 32'd0);
    chk("abort busy",   {31'd0, hif.busy}, 32'd0);
    chk("abort done",   {31'd0, hif.done | (ndone != 0)}, 32'd0);
    chk("abort rdata",  {28'd0, hif.rdata}, 32'h5);
    chk_cfg("abort cfg held", 4'b1011);
    run_full("after abort", 4'h6, 4'h6);

    // Request pulse while busy is ignored
    hif.wdata = 4'h9;
    hif.req   = 1'b1;
    tick();
    hif.req   = 1'b0;
    ndone     = 0;
    for (int c = 2; c <= 5; c++) tick();
    hif.wdata = 4'hF;
    hif.req   = 1'b1;
    tick();
    hif.req   = 1'b0;
    for (int c = 6; c <= 20; c++) begin
      if (hif.done) ndone++;
      tick();
    end
    chk("busy req done count", ndone, 32'd1);
    chk("busy req rdata", {28'd0, hif.rdata}, 32'h9);
    chk("busy req idle", {31'd0, hif.busy}, 32'd0);

    // Request held high: done every 12 cycles
    hif.wdata = 4'h7;
    hif.req   = 1'b1;
    ndone = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (hif.done) begin
        ndone++;
        if (ndone == 1) d1 = c;
        if (ndone == 2) d2 = c;
      end
    end
    hif.req = 1'b0;
    chk("held first done", d1, 32'd11);
    chk("held second done", d2, 32'd23);
    chk("held done count", ndone, 32'd2);
    cyc = 0;
    while (hif.busy && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("held drain", {31'd0, hif.busy}, 32'd0);
    chk("held rdata", {28'd0, hif.rdata}, 32'h7);

    // Reset in the middle of SHIFT (cycle 7)
    hif.cfg_mode = 1'b1; hif.cfg_intest = 1'b1; hif.cfg_rstb_en = 1'b1; hif.cfg_rstb = 1'b0;
    hif.wdata = 4'hB;
    hif.req   = 1'b1;
    tick();
    hif.req   = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    chk("pre-reset scanen", {31'd0, scanen}, 32'd1);
    rstb = 1'b0;
    #1;
    chk("mid rst busy",   {31'd0, hif.busy}, 32'd0);
    chk("mid rst done",   {31'd0, hif.done}, 32'd0);
    chk("mid rst rdata",  {28'd0, hif.rdata}, 32'd0);
    chk("mid rst clkdr",  {31'd0, clkdr}, 32'd0);
    chk("mid rst scanen", {31'd0, scanen}, 32'd0);
    chk("mid rst tx",     {31'd0, tx}, 32'd0);
    chk_cfg("mid rst cfg", 4'b0001);
    tick();
    rstb = 1'b1;
    tick();
    run_full("post reset", 4'hC, 4'hC);
    chk_cfg("post reset cfg", 4'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
